// File: rtl/twiddle_pkg.sv
// Shared definitions for the streaming twiddle generator: size helpers,
// FSM state encoding and the elaboration-time quarter-wave cosine table.
package twiddle_pkg;

    typedef enum logic [1:0] {
        TW_IDLE  = 2'd0,
        TW_RUN   = 2'd1,
        TW_DRAIN = 2'd2
    } tw_state_e;

    function automatic int tw_n(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic int tw_half(input int log2n);
        return 1 << (log2n - 1);
    endfunction

    function automatic int tw_quarter(input int log2n);
        return 1 << (log2n - 2);
    endfunction

    function automatic int tw_sw(input int log2n);
        return $clog2(log2n);
    endfunction

    localparam int     COS_SH = 28;
    localparam longint PI_S   = 64'sd843314857;  // pi * 2^28

    // round(cos(2*pi*m/N) * 2^frac) for 0 <= m <= N/4, via a fixed-point Taylor series
    function automatic int tw_cos_q(input int m, input int log2n, input int frac);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (2 * PI_S * m) >>> log2n;
        x2   = (x * x) >>> COS_SH;
        term = longint'(1) <<< COS_SH;
        sum  = term;
        for (int i = 1; i <= 10; i++) begin
            term = -((term * x2) >>> COS_SH) / longint'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        return int'(((sum <<< frac) + (longint'(1) <<< (COS_SH - 1))) >>> COS_SH);
    endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine table, N/4+1 live entries, two combinational read ports.
module twiddle_quarter_rom
    import twiddle_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LOG2N = 5
) (
    input  logic        [LOG2N-2:0] i_addr_a,
    input  logic        [LOG2N-2:0] i_addr_b,
    output logic signed [WIDTH-1:0] o_data_a,
    output logic signed [WIDTH-1:0] o_data_b
);

    localparam int DEPTH = 1 << (LOG2N - 1);

    logic signed [WIDTH-1:0] w_table [0:DEPTH-1];

    // Entries beyond N/4 are never addressed by the fold; tie them off.
    for (genvar m = 0; m < DEPTH; m++) begin : g_tab
        localparam logic signed [WIDTH-1:0] CV =
            (m <= tw_quarter(LOG2N)) ? WIDTH'(tw_cos_q(m, LOG2N, FRAC)) : '0;
        assign w_table[m] = CV;
    end

    assign o_data_a = w_table[i_addr_a];
    assign o_data_b = w_table[i_addr_b];

endmodule

// File: rtl/twiddle_stream_gen.sv
// Streaming radix-2 DIT twiddle generator: per-stage run of N/2 twiddles through
// a three-register pipeline (address, table read, fold) with a global stall.
module twiddle_stream_gen
    import twiddle_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LOG2N = 5,
    parameter int SW    = tw_sw(LOG2N)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic        [SW-1:0]    i_stage,
    input  logic                    i_inverse,
    output logic                    o_busy,
    output logic                    o_tw_valid,
    input  logic                    i_tw_ready,
    output logic signed [WIDTH-1:0] o_tw_re,
    output logic signed [WIDTH-1:0] o_tw_im,
    output logic        [LOG2N-2:0] o_tw_idx,
    output logic                    o_tw_last,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int              HW        = LOG2N - 1;
    localparam logic [HW-1:0]   B_LAST    = HW'(tw_half(LOG2N) - 1);
    localparam logic [HW-1:0]   QTR       = HW'(tw_quarter(LOG2N));
    localparam logic [SW:0]     STAGE_LIM = (SW + 1)'(LOG2N);
    localparam logic [SW-1:0]   SH_MAX    = SW'(HW);

    tw_state_e     r_state, w_state_nxt;
    logic [HW-1:0] r_b;
    logic [SW-1:0] r_stage;
    logic          r_inv;
    logic          r_err;
    logic          w_adv, w_legal, w_accept, w_issue, w_hs_last;

    assign w_adv     = !o_tw_valid || i_tw_ready;
    assign w_hs_last = o_tw_valid && i_tw_ready && o_tw_last;
    assign w_legal   = {1'b0, i_stage} < STAGE_LIM;
    assign w_accept  = (r_state == TW_IDLE) && i_start && w_legal;
    assign w_issue   = (r_state == TW_RUN) && w_adv;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TW_IDLE:  if (w_accept) w_state_nxt = TW_RUN;
            TW_RUN:   if (w_issue && r_b == B_LAST) w_state_nxt = TW_DRAIN;
            TW_DRAIN: if (w_hs_last) w_state_nxt = TW_IDLE;
            default:  w_state_nxt = TW_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= TW_IDLE;
            r_b     <= '0;
            r_stage <= '0;
            r_inv   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= (r_state == TW_IDLE) && i_start && !w_legal;
            if (w_accept) begin
                r_b     <= '0;
                r_stage <= i_stage;
                r_inv   <= i_inverse;
            end else if (w_issue) begin
                r_b <= r_b + HW'(1);
            end
        end
    end

    // Butterfly index -> exponent k, then quadrant fold into two table addresses
    logic [HW-1:0] w_mask, w_k, w_kp, w_addr_re, w_addr_im;
    logic [SW-1:0] w_sh;
    logic          w_hi;

    always_comb begin
        w_mask    = ~({HW{1'b1}} << r_stage);
        w_sh      = SH_MAX - r_stage;
        w_k       = (r_b & w_mask) << w_sh;
        w_hi      = w_k > QTR;
        w_kp      = w_k - QTR;
        w_addr_re = w_hi ? (QTR - w_kp) : w_k;
        w_addr_im = w_hi ? w_kp : (QTR - w_k);
    end

    // P1: index and table addresses
    logic                    r_vld_p1, r_last_p1, r_hi_p1;
    logic [HW-1:0]           r_idx_p1, r_are_p1, r_aim_p1;
    logic signed [WIDTH-1:0] w_c_re, w_c_im;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_hi_p1   <= 1'b0;
            r_idx_p1  <= '0;
            r_are_p1  <= '0;
            r_aim_p1  <= '0;
        end else if (w_adv) begin
            r_vld_p1  <= (r_state == TW_RUN);
            r_last_p1 <= (r_b == B_LAST);
            r_hi_p1   <= w_hi;
            r_idx_p1  <= r_b;
            r_are_p1  <= w_addr_re;
            r_aim_p1  <= w_addr_im;
        end
    end

    twiddle_quarter_rom #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .LOG2N (LOG2N)
    ) u_rom (
        .i_addr_a (r_are_p1),
        .i_addr_b (r_aim_p1),
        .o_data_a (w_c_re),
        .o_data_b (w_c_im)
    );

    // P2: table reads
    logic                    r_vld_p2, r_last_p2, r_hi_p2;
    logic [HW-1:0]           r_idx_p2;
    logic signed [WIDTH-1:0] r_cre_p2, r_cim_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
            r_hi_p2   <= 1'b0;
            r_idx_p2  <= '0;
            r_cre_p2  <= '0;
            r_cim_p2  <= '0;
        end else if (w_adv) begin
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
            r_hi_p2   <= r_hi_p1;
            r_idx_p2  <= r_idx_p1;
            r_cre_p2  <= w_c_re;
            r_cim_p2  <= w_c_im;
        end
    end

    // P3: sign fold and optional conjugate; |C| <= 2^FRAC so negation cannot overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tw_valid <= 1'b0;
            o_tw_last  <= 1'b0;
            o_tw_idx   <= '0;
            o_tw_re    <= '0;
            o_tw_im    <= '0;
        end else if (w_adv) begin
            o_tw_valid <= r_vld_p2;
            o_tw_last  <= r_last_p2;
            o_tw_idx   <= r_idx_p2;
            o_tw_re    <= r_hi_p2 ? -r_cre_p2 : r_cre_p2;
            o_tw_im    <= r_inv ? r_cim_p2 : -r_cim_p2;
        end
    end

    assign o_busy = (r_state != TW_IDLE);
    assign o_done = w_hs_last;
    assign o_err  = r_err;

endmodule
